// File: rtl/uart_load_pkg.sv
// Shared types and constants for the UART host-link load controller.
// Optional build macro: UART_LOAD_CHECKSUM_EN adds the S_CHK state.
package uart_load_pkg;

    // Host command field, bits [7:6] of a command byte (2'b11 is illegal)
    localparam logic [1:0] CMD_LOAD = 2'b00;
    localparam logic [1:0] CMD_RUN  = 2'b01;
    localparam logic [1:0] CMD_HOLD = 2'b10;

    // Default reply bytes
    localparam logic [7:0] DEF_ACK_BYTE = 8'hA5;
    localparam logic [7:0] DEF_ERR_BYTE = 8'hE1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LEN,
        S_HI,
        S_LO,
        S_WRITE,
        S_RUN,
        S_TX_HI,
        S_TX_LO,
        S_TX_ONE
`ifdef UART_LOAD_CHECKSUM_EN
        , S_CHK
`endif
    } state_t;

    function automatic logic is_tx_state(state_t s);
        return (s == S_TX_HI) || (s == S_TX_LO) || (s == S_TX_ONE);
    endfunction

endpackage

// File: rtl/uart_load_ctrl_if.sv
// Host UART / CPU load-port bundle. The controller is the slave side;
// the UART pair and the CPU together form the master side.
interface uart_load_ctrl_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        tx_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        cpu_reset;
    logic        uart_en;
    logic [15:0] uart_data;
    logic [1:0]  uart_sel;
    logic        cpu_done;
    logic [15:0] cpu_result;
    logic        busy;

    modport master (
        output rx_valid, rx_data, tx_ready, cpu_done, cpu_result,
        input  tx_valid, tx_data, cpu_reset, uart_en, uart_data, uart_sel, busy
    );

    modport slave (
        input  rx_valid, rx_data, tx_ready, cpu_done, cpu_result,
        output tx_valid, tx_data, cpu_reset, uart_en, uart_data, uart_sel, busy
    );
endinterface

// File: rtl/uart_load_ctrl_assembler.sv
// Pairs a high byte and a low byte into a 16-bit word; word_vld pulses
// for one cycle, the cycle after the low byte is taken.
module uart_word_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [7:0]  byte_in,
    output logic [15:0] word,
    output logic        word_vld
);
    logic [7:0] hi_q;

    // Hold the high byte, then publish the full word with a one-cycle strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q     <= '0;
            word     <= '0;
            word_vld <= 1'b0;
        end else begin
            word_vld <= lo_we;
            if (hi_we) hi_q <= byte_in;
            if (lo_we) word <= {hi_q, byte_in};
        end
    end
endmodule

// File: rtl/uart_load_ctrl.sv
// Host-link sequencer: decodes host commands, streams words into the CPU
// load port, runs the CPU and returns its 16-bit result over TX.
// Optional build macro: UART_LOAD_CHECKSUM_EN (trailing XOR byte on LOAD).
module uart_load_ctrl
    import uart_load_pkg::*;
#(
    parameter int unsigned RUN_TIMEOUT = 65535,
    parameter logic [7:0]  ACK_BYTE    = DEF_ACK_BYTE,
    parameter logic [7:0]  ERR_BYTE    = DEF_ERR_BYTE
) (
    input  logic             clk,
    input  logic             reset,
    uart_load_ctrl_if.slave  bus
);
    localparam int          TW      = $clog2(RUN_TIMEOUT + 2);
    localparam logic [TW-1:0] TMO_MAX = TW'(RUN_TIMEOUT);

    state_t          state_q, state_d;
    logic [8:0]      cnt_q;          // words left; 256 fits for N=0
    logic [TW-1:0]   tmo_q;
    logic [7:0]      tx_data_q;
    logic [7:0]      res_lo_q;
    logic [1:0]      sel_q;
    logic            cpu_reset_q;
    logic            last_word;
    logic [1:0]      cmd;
`ifdef UART_LOAD_CHECKSUM_EN
    logic [7:0]      chk_q;
`endif

    assign cmd       = bus.rx_data[7:6];
    assign last_word = (cnt_q == 9'd1);

    uart_word_assembler u_asm (
        .clk      (clk),
        .reset    (reset),
        .hi_we    ((state_q == S_HI) && bus.rx_valid),
        .lo_we    ((state_q == S_LO) && bus.rx_valid),
        .byte_in  (bus.rx_data),
        .word     (bus.uart_data),
        .word_vld (bus.uart_en)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state decode; bytes arriving outside IDLE/LEN/HI/LO/CHK are dropped
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (bus.rx_valid) begin
                unique case (cmd)
                    CMD_LOAD: state_d = S_LEN;
                    CMD_RUN:  state_d = S_RUN;
                    CMD_HOLD: state_d = S_IDLE;
                    default:  state_d = S_TX_ONE;
                endcase
            end
            S_LEN:   if (bus.rx_valid) state_d = S_HI;
            S_HI:    if (bus.rx_valid) state_d = S_LO;
            S_LO:    if (bus.rx_valid) state_d = S_WRITE;
`ifdef UART_LOAD_CHECKSUM_EN
            S_WRITE: state_d = last_word ? S_CHK : S_HI;
            S_CHK:   if (bus.rx_valid) state_d = S_TX_ONE;
`else
            S_WRITE: state_d = last_word ? S_TX_ONE : S_HI;
`endif
            S_RUN: begin
                if (bus.cpu_done)          state_d = S_TX_HI;
                else if (tmo_q == TMO_MAX) state_d = S_TX_ONE;
            end
            S_TX_HI:  if (bus.tx_ready) state_d = S_TX_LO;
            S_TX_LO:  if (bus.tx_ready) state_d = S_IDLE;
            S_TX_ONE: if (bus.tx_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Datapath: counters, CPU reset, select latch and the outgoing byte
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            tmo_q       <= '0;
            tx_data_q   <= '0;
            res_lo_q    <= '0;
            sel_q       <= '0;
            cpu_reset_q <= 1'b1;
`ifdef UART_LOAD_CHECKSUM_EN
            chk_q       <= '0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: if (bus.rx_valid) begin
                    unique case (cmd)
                        CMD_LOAD: begin
                            sel_q       <= bus.rx_data[1:0];
                            cpu_reset_q <= 1'b1;
                        end
                        CMD_RUN: begin
                            tmo_q       <= '0;
                            cpu_reset_q <= 1'b0;
                        end
                        CMD_HOLD: cpu_reset_q <= 1'b1;
                        default:  tx_data_q   <= ERR_BYTE;
                    endcase
                end
                S_LEN: if (bus.rx_valid) begin
                    cnt_q <= (bus.rx_data == 8'd0) ? 9'd256 : {1'b0, bus.rx_data};
`ifdef UART_LOAD_CHECKSUM_EN
                    chk_q <= '0;
`endif
                end
`ifdef UART_LOAD_CHECKSUM_EN
                S_HI, S_LO: if (bus.rx_valid) chk_q <= chk_q ^ bus.rx_data;
                S_CHK: if (bus.rx_valid)
                    tx_data_q <= (bus.rx_data == chk_q) ? ACK_BYTE : ERR_BYTE;
                S_WRITE: cnt_q <= cnt_q - 9'd1;
`else
                S_WRITE: begin
                    cnt_q <= cnt_q - 9'd1;
                    if (last_word) tx_data_q <= ACK_BYTE;
                end
`endif
                // Done beats timeout when both land in the same cycle
                S_RUN: begin
                    if (bus.cpu_done) begin
                        tx_data_q   <= bus.cpu_result[15:8];
                        res_lo_q    <= bus.cpu_result[7:0];
                        cpu_reset_q <= 1'b1;
                    end else if (tmo_q == TMO_MAX) begin
                        tx_data_q   <= ERR_BYTE;
                        cpu_reset_q <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                S_TX_HI: if (bus.tx_ready) tx_data_q <= res_lo_q;
                default: ;
            endcase
        end
    end

    // Outputs decoded from state plus the registered datapath values
    always_comb begin
        bus.tx_valid  = is_tx_state(state_q);
        bus.busy      = (state_q != S_IDLE);
        bus.tx_data   = tx_data_q;
        bus.cpu_reset = cpu_reset_q;
        bus.uart_sel  = sel_q;
    end
endmodule

// File: tb/tb_uart_load_ctrl.sv
// Scoreboard bench for uart_load_ctrl: expected CPU writes and TX bytes are
// queued as stimulus is driven and popped by a monitor on the falling edge.
module tb_uart_load_ctrl;
    localparam int TMO = 50;

    logic clk = 1'b0;
    logic reset = 1'b1;

    uart_load_ctrl_if bus();

    uart_load_ctrl #(.RUN_TIMEOUT(TMO), .ACK_BYTE(8'hA5), .ERR_BYTE(8'hE1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct { logic [15:0] data; logic [1:0] sel; } wr_t;
    wr_t         exp_wr[$];
    logic [7:0]  exp_tx[$];
    logic [15:0] ld_words[$];
    int n_checks = 0;
    int n_fail   = 0;

    // Monitor: every CPU write and every TX handshake must match the scoreboard
    always @(negedge clk) begin : mon
        wr_t        e;
        logic [7:0] b;
        if (!reset && bus.uart_en === 1'b1) begin
            n_checks++;
            if (exp_wr.size() == 0) begin
                n_fail++;
                $display("FAIL uart_en_unexpected: got data=%h, required no write", bus.uart_data);
            end else begin
                e = exp_wr.pop_front();
                if (bus.uart_data !== e.data) begin
                    n_fail++;
                    $display("FAIL uart_data: got %h, required %h", bus.uart_data, e.data);
                end
                n_checks++;
                if (bus.uart_sel !== e.sel) begin
                    n_fail++;
                    $display("FAIL uart_sel: got %0d, required %0d", bus.uart_sel, e.sel);
                end
                n_checks++;
                if (bus.cpu_reset !== 1'b1) begin
                    n_fail++;
                    $display("FAIL cpu_reset_during_load: got %b, required 1", bus.cpu_reset);
                end
            end
        end
        if (!reset && bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) begin
            n_checks++;
            if (exp_tx.size() == 0) begin
                n_fail++;
                $display("FAIL tx_unexpected: got %h, required no byte", bus.tx_data);
            end else begin
                b = exp_tx.pop_front();
                if (bus.tx_data !== b) begin
                    n_fail++;
                    $display("FAIL tx_data: got %h, required %h", bus.tx_data, b);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int max);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < max; k++) begin
            @(posedge clk); #2;
            if (bus.busy === 1'b0 && exp_tx.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_idle: busy=%b tx_pending=%0d after %0d cycles, required busy=0 pending=0",
                     name, bus.busy, exp_tx.size(), max);
        end
        n_checks++;
        if (exp_wr.size() != 0) begin
            n_fail++;
            $display("FAIL %s_writes: %0d writes missing, required 0", name, exp_wr.size());
        end
        exp_tx.delete();
        exp_wr.delete();
    endtask

    // LOAD of the words in ld_words; bad_chk corrupts the checksum byte
    task automatic load_words(input logic [1:0] sel, input bit bad_chk);
        logic [7:0] x;
        wr_t        e;
        x = 8'h00;
        exp_tx.push_back(bad_chk ? 8'hE1 : 8'hA5);
        send_byte({6'b0, sel});
        send_byte(8'(ld_words.size()));
        foreach (ld_words[i]) begin
            e.data = ld_words[i];
            e.sel  = sel;
            exp_wr.push_back(e);
            x = x ^ ld_words[i][15:8] ^ ld_words[i][7:0];
            send_byte(ld_words[i][15:8]);
            send_byte(ld_words[i][7:0]);
        end
`ifdef UART_LOAD_CHECKSUM_EN
        send_byte(bad_chk ? ~x : x);
`endif
    endtask

    task automatic check_reset_values(input string name);
        n_checks++;
        if (bus.cpu_reset !== 1'b1) begin n_fail++; $display("FAIL %s_cpu_reset: got %b, required 1", name, bus.cpu_reset); end
        n_checks++;
        if (bus.uart_en !== 1'b0) begin n_fail++; $display("FAIL %s_uart_en: got %b, required 0", name, bus.uart_en); end
        n_checks++;
        if (bus.uart_data !== 16'h0) begin n_fail++; $display("FAIL %s_uart_data: got %h, required 0000", name, bus.uart_data); end
        n_checks++;
        if (bus.uart_sel !== 2'd0) begin n_fail++; $display("FAIL %s_uart_sel: got %0d, required 0", name, bus.uart_sel); end
        n_checks++;
        if (bus.tx_valid !== 1'b0) begin n_fail++; $display("FAIL %s_tx_valid: got %b, required 0", name, bus.tx_valid); end
        n_checks++;
        if (bus.tx_data !== 8'h0) begin n_fail++; $display("FAIL %s_tx_data: got %h, required 00", name, bus.tx_data); end
        n_checks++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL %s_busy: got %b, required 0", name, bus.busy); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check_reset_values("reset");
    endtask

    task automatic test_load();
        ld_words = '{16'h1234, 16'hABCD};
        load_words(2'd1, 1'b0);
        wait_idle("load", 100);
    endtask

    task automatic test_len256();
        ld_words.delete();
        for (int i = 0; i < 256; i++) ld_words.push_back({8'(i), 8'(i * 7 + 3)});
        load_words(2'd3, 1'b0);
        wait_idle("len256", 100);
    endtask

    task automatic test_run();
        exp_tx.push_back(8'hBE);
        exp_tx.push_back(8'hEF);
        send_byte(8'h40);
        n_checks++;
        if (bus.cpu_reset !== 1'b0) begin n_fail++; $display("FAIL run_cpu_reset_low: got %b, required 0", bus.cpu_reset); end
        repeat (19) @(posedge clk);
        #1;
        bus.cpu_done   = 1'b1;
        bus.cpu_result = 16'hBEEF;
        n_checks++;
        if (bus.tx_valid !== 1'b0) begin n_fail++; $display("FAIL run_tx_early: got %b, required 0", bus.tx_valid); end
        @(posedge clk); #1;
        bus.cpu_done = 1'b0;
        n_checks++;
        if (bus.tx_valid !== 1'b1) begin n_fail++; $display("FAIL run_tx_latency: got %b, required 1", bus.tx_valid); end
        n_checks++;
        if (bus.tx_data !== 8'hBE) begin n_fail++; $display("FAIL run_tx_first: got %h, required be", bus.tx_data); end
        n_checks++;
        if (bus.cpu_reset !== 1'b1) begin n_fail++; $display("FAIL run_cpu_reset_back: got %b, required 1", bus.cpu_reset); end
        wait_idle("run", 50);
    endtask

    task automatic test_timeout();
        exp_tx.push_back(8'hE1);
        send_byte(8'h40);
        repeat (40) @(posedge clk);
        #1;
        n_checks++;
        if (bus.tx_valid !== 1'b0 || bus.cpu_reset !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_early: tx_valid=%b cpu_reset=%b, required 0 0", bus.tx_valid, bus.cpu_reset);
        end
        wait_idle("timeout", 100);
        n_checks++;
        if (bus.cpu_reset !== 1'b1) begin n_fail++; $display("FAIL timeout_cpu_reset: got %b, required 1", bus.cpu_reset); end
    endtask

    task automatic test_backpressure();
        exp_tx.push_back(8'hBE);
        exp_tx.push_back(8'hEF);
        bus.tx_ready = 1'b0;
        send_byte(8'h40);
        repeat (5) @(posedge clk);
        #1;
        bus.cpu_done   = 1'b1;
        bus.cpu_result = 16'hBEEF;
        @(posedge clk); #1;
        bus.cpu_done = 1'b0;
        for (int k = 0; k < 10; k++) begin
            n_checks++;
            if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'hBE) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: tx_valid=%b tx_data=%h, required 1 be", k, bus.tx_valid, bus.tx_data);
            end
            @(posedge clk); #1;
        end
        bus.tx_ready = 1'b1;
        wait_idle("backpressure", 20);
    endtask

    task automatic test_illegal();
        exp_tx.push_back(8'hE1);
        send_byte(8'hC3);
        wait_idle("illegal", 20);
    endtask

    task automatic test_reset_mid_load();
        send_byte(8'h00);
        send_byte(8'h03);
        send_byte(8'h11);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        check_reset_values("midload");
        repeat (3) @(posedge clk);
        ld_words = '{16'h55AA};
        load_words(2'd2, 1'b0);
        wait_idle("after_reset", 50);
    endtask

`ifdef UART_LOAD_CHECKSUM_EN
    task automatic test_checksum();
        ld_words = '{16'h1234};
        load_words(2'd0, 1'b0);
        wait_idle("chk_good", 50);
        load_words(2'd0, 1'b1);
        wait_idle("chk_bad", 50);
        n_checks++;
        if (bus.cpu_reset !== 1'b1) begin n_fail++; $display("FAIL chk_bad_cpu_reset: got %b, required 1", bus.cpu_reset); end
    endtask
`endif

    initial begin
        bus.rx_valid   = 1'b0;
        bus.rx_data    = 8'h00;
        bus.tx_ready   = 1'b1;
        bus.cpu_done   = 1'b0;
        bus.cpu_result = 16'h0000;
        test_reset();
        test_load();
        test_run();
        test_timeout();
        test_backpressure();
        test_illegal();
        test_reset_mid_load();
        test_len256();
`ifdef UART_LOAD_CHECKSUM_EN
        test_checksum();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
